accumulator_mc: RTL and testbench
=================================

# accumulator_mc

Parametrised multi-channel signed fixed-point stream accumulator, the next generation of the single-channel packet accumulator. Sums the beats of each packet, separately per channel selected by `tid`, and emits one result per packet on `tlast`. Adds output backpressure, configurable width and channel count, selectable saturate/wrap arithmetic, an overflow flag and a beat count. Sits between a sample-producing stream stage and any downstream consumer that may stall.

## Interface
- `DATA_W`, 32: input sample width, signed two's complement.
- `ACC_W`, 48: internal accumulator width; must be >= `DATA_W`.
- `OUT_W`, 32: result width; must be <= `ACC_W`.
- `CHANNELS`, 4: number of independent accumulation channels (>= 1).
- `SATURATE`, 1: 1 = saturate at bounds, 0 = two's-complement wrap.
- `CNT_W`, 16: beat-counter width.
- Derived `ID_W` = max(1, clog2(`CHANNELS`)).

Ports:
- `aclk`  in  1  clock; all logic on its rising edge.
- `aresetn`  in  1  asynchronous active-low reset.
- `s_clear`  in  1  synchronous clear of all channel state.
- `s_axis_a_tvalid`  in  1  input beat valid.
- `s_axis_a_tready`  out  1  input beat accepted when high with tvalid.
- `s_axis_a_tdata`  in  `DATA_W`  signed sample.
- `s_axis_a_tid`  in  `ID_W`  channel index.
- `s_axis_a_tlast`  in  1  last beat of the packet for this channel.
- `m_axis_result_tvalid`  out  1  result valid.
- `m_axis_result_tready`  in  1  downstream accepts result.
- `m_axis_result_tdata`  out  `OUT_W`  packet sum.
- `m_axis_result_tid`  out  `ID_W`  channel of the result.
- `m_axis_result_tlast`  out  1  high whenever tvalid is high; one beat per result.
- `m_axis_result_tuser`  out  `CNT_W`+1  {overflow flag, beat count}.

## Operation
- Per-channel state: `acc[ch]` (`ACC_W`), `cnt[ch]` (`CNT_W`), sticky `ovf[ch]`. All are zero after reset.
- The input handshake is accepted when `tvalid && tready`. Beats with `tid >= CHANNELS` are accepted and discarded, and produce no result.
- On an accepted beat:
  - `sum` = `acc[ch]` + sign-extended `tdata`.
  - If `sum` exceeds the `ACC_W` signed range, set `ovf[ch]`. The sum then clamps to the bound when `SATURATE`=1, or wraps when `SATURATE`=0.
  - `cnt` increments, saturating at all-ones.
- Non-last beat: write back `acc`, `cnt` and `ovf`.
- Last beat:
  - Load the output register with `sum` reduced to `OUT_W`: clamped if `SATURATE`=1, low bits if 0.
  - If the reduction changed the value, `ovf` for this result is 1.
  - `tuser` = {ovf incl. this beat, cnt incl. this beat}.
  - Clear `acc[ch]`, `cnt[ch]` and `ovf[ch]` to 0.
- Channels interleave freely. Packets on different channels never affect each other.
- `s_clear`:
  - Zeroes all `acc`, `cnt` and `ovf` in the next cycle.
  - A beat accepted in the same cycle is applied on top of zero state (`acc` = `tdata`, `cnt` = 1). If it is a last beat, its result is emitted normally.
  - The output register is unaffected.
- Output is a single register:
  - `tvalid` sets on a last-beat accept.
  - `tvalid` clears on `m_tvalid && m_tready` unless a new last beat is accepted in the same cycle, in which case the register reloads.

## Timing
- `s_axis_a_tready` = `aresetn` && (!`m_axis_result_tvalid` || `m_axis_result_tready`).
- Input stalls only while a result is pending and not taken.
- Full throughput is one beat per cycle when downstream `tready` is held high.
- Latency: the result is valid the cycle after the tlast beat is accepted, i.e. a 1-cycle registered output.
- Output data, id and user are held stable while `tvalid` is high and `tready` is low.
- Reset:
  - Asynchronous assertion clears all state.
  - All `m_axis_result_*` outputs are 0 and `s_axis_a_tready` is 0 during reset.
  - `s_axis_a_tready` returns to 1 on the first edge after deassertion.
- Reset mid-packet discards the partial sums. There is no result for the interrupted packet.
- A single-beat packet (tlast on the first beat) yields `tdata` with count 1.

## Test plan
- Channel 0, beats 1..10 with tlast on 10, `tready` held 1 -> one result: 55, tid 0, tuser {0, 10}.
- Channels 0/1 interleaved, 1..10 on ch0 and 11..20 on ch1 -> results 55 (tid 0) and 155 (tid 1), each the cycle after its tlast.
- Result pending with `m_tready` low for 5 cycles -> `s_tready` low, result held stable, no input lost; the next packet is correct after release.
- `SATURATE`=1, `OUT_W`=16, beats 30000 + 30000 (last) -> tdata 32767, ovf 1. The same stimulus with `SATURATE`=0 -> tdata -5536, ovf 1.
- `s_clear` asserted with ch2 holding 7 while beat 5 (non-last) is accepted, then beat 1 with tlast -> result 6, count 2.
- `aresetn` pulsed low mid-packet on ch3 after beats 4 and 4, then beats 2 and 3 (last) -> result 5, count 2.

Source files
------------

// File: rtl/accumulator_mc.sv
// Multi-channel signed stream accumulator: sums each packet per channel (tid) and
// emits one registered result per tlast, with saturate/wrap arithmetic and backpressure.
module accumulator_mc #(
   parameter int DATA_W   = 32,
   parameter int ACC_W    = 48,
   parameter int OUT_W    = 32,
   parameter int CHANNELS = 4,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 16,
   localparam int ID_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              s_clear,
   input  logic              s_axis_a_tvalid,
   output logic              s_axis_a_tready,
   input  logic [DATA_W-1:0] s_axis_a_tdata,
   input  logic [ID_W-1:0]   s_axis_a_tid,
   input  logic              s_axis_a_tlast,
   output logic              m_axis_result_tvalid,
   input  logic              m_axis_result_tready,
   output logic [OUT_W-1:0]  m_axis_result_tdata,
   output logic [ID_W-1:0]   m_axis_result_tid,
   output logic              m_axis_result_tlast,
   output logic [CNT_W:0]    m_axis_result_tuser
);

   logic signed [ACC_W-1:0] acc [CHANNELS];
   logic [CNT_W-1:0]        cnt [CHANNELS];
   logic [CHANNELS-1:0]     ovf;
   logic                    ready_en;

   logic                    ch_ok, take_beat, res_load;
   logic signed [ACC_W-1:0] acc_cur, acc_new, low_ext;
   logic signed [ACC_W:0]   sum_full;
   logic [CNT_W-1:0]        cnt_cur, cnt_new;
   logic                    ovf_cur, ovf_new, acc_ovf, red_chg;
   logic [OUT_W-1:0]        out_low, out_new;

   assign s_axis_a_tready     = aresetn && ready_en && (!m_axis_result_tvalid || m_axis_result_tready);
   assign take_beat           = s_axis_a_tvalid && s_axis_a_tready && ch_ok;
   assign res_load            = take_beat && s_axis_a_tlast;
   assign m_axis_result_tlast = m_axis_result_tvalid;

   // A clear in the same cycle as a beat makes the beat start from zero state.
   always_comb begin
      ch_ok   = 1'b0;
      acc_cur = '0;
      cnt_cur = '0;
      ovf_cur = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (s_axis_a_tid == ID_W'(i)) begin
            ch_ok = 1'b1;
            if (!s_clear) begin
               acc_cur = acc[i];
               cnt_cur = cnt[i];
               ovf_cur = ovf[i];
            end
         end
      end
   end

   always_comb begin
      sum_full = (ACC_W+1)'(acc_cur) + (ACC_W+1)'($signed(s_axis_a_tdata));
      acc_ovf  = sum_full[ACC_W] != sum_full[ACC_W-1];
      if (acc_ovf && SATURATE != 0)
         acc_new = sum_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         acc_new = sum_full[ACC_W-1:0];
      out_low = acc_new[OUT_W-1:0];
      low_ext = ACC_W'($signed(out_low));
      red_chg = low_ext != acc_new;
      if (red_chg && SATURATE != 0)
         out_new = acc_new[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      else
         out_new = out_low;
      cnt_new = (&cnt_cur) ? cnt_cur : cnt_cur + CNT_W'(1);
      ovf_new = ovf_cur | acc_ovf;
   end

   // Per-channel state: a last beat retires the packet, clear zeroes everything else.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
         ovf <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (take_beat && s_axis_a_tid == ID_W'(i)) begin
               if (s_axis_a_tlast) begin
                  acc[i] <= '0;
                  cnt[i] <= '0;
                  ovf[i] <= 1'b0;
               end else begin
                  acc[i] <= acc_new;
                  cnt[i] <= cnt_new;
                  ovf[i] <= ovf_new;
               end
            end else if (s_clear) begin
               acc[i] <= '0;
               cnt[i] <= '0;
               ovf[i] <= 1'b0;
            end
         end
      end
   end

   // Single output register; a new result reloads it even while the old one is taken.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_result_tvalid <= 1'b0;
         m_axis_result_tdata  <= '0;
         m_axis_result_tid    <= '0;
         m_axis_result_tuser  <= '0;
      end else if (res_load) begin
         m_axis_result_tvalid <= 1'b1;
         m_axis_result_tdata  <= out_new;
         m_axis_result_tid    <= s_axis_a_tid;
         m_axis_result_tuser  <= {ovf_new | red_chg, cnt_new};
      end else if (m_axis_result_tvalid && m_axis_result_tready) begin
         m_axis_result_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         ready_en <= 1'b0;
      else
         ready_en <= 1'b1;
   end

endmodule

// File: tb/tb_accumulator_mc.sv
// Bench for accumulator_mc: three instances (32-bit out, 16-bit saturate, 16-bit wrap)
// share one stimulus stream and are checked every cycle against an arithmetic model.
module tb_accumulator_mc;

   localparam longint ACC_MAX = 64'sd140737488355327;
   localparam longint ACC_MIN = -64'sd140737488355328;
   localparam longint ACC_SPAN = 64'sd281474976710656;

   typedef struct {
      longint data;
      int     id;
      int     cnt;
      bit     ovf;
   } res_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        s_clear, s_valid, s_last, m_tready;
   logic [31:0] s_data;
   logic [1:0]  s_id;

   logic        rdy0, rdy1, rdy2, mv0, mv1, mv2, ml0, ml1, ml2;
   logic [1:0]  mid0, mid1, mid2;
   logic [31:0] md0;
   logic [15:0] md1, md2;
   logic [16:0] mu0, mu1, mu2;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   longint m_acc [3][4];
   int     m_cnt [3][4];
   bit     m_ovf [3][4];
   bit     e_valid, e_ready_en, beat;
   int     e_id;
   longint e_data [3];
   int     e_cnt [3];
   bit     e_ovf [3];
   int     out_w [3] = '{32, 16, 16};
   bit     sat   [3] = '{1'b1, 1'b1, 1'b0};
   longint ms, lim, mr;
   int     mc;
   bit     mo;
   res_t   rq0[$], rq1[$], rq2[$];

   always #5 aclk = ~aclk;

   accumulator_mc dut0 (
      .aclk(aclk), .aresetn(aresetn), .s_clear(s_clear),
      .s_axis_a_tvalid(s_valid), .s_axis_a_tready(rdy0), .s_axis_a_tdata(s_data),
      .s_axis_a_tid(s_id), .s_axis_a_tlast(s_last),
      .m_axis_result_tvalid(mv0), .m_axis_result_tready(m_tready), .m_axis_result_tdata(md0),
      .m_axis_result_tid(mid0), .m_axis_result_tlast(ml0), .m_axis_result_tuser(mu0));

   accumulator_mc #(.OUT_W(16), .SATURATE(1)) dut1 (
      .aclk(aclk), .aresetn(aresetn), .s_clear(s_clear),
      .s_axis_a_tvalid(s_valid), .s_axis_a_tready(rdy1), .s_axis_a_tdata(s_data),
      .s_axis_a_tid(s_id), .s_axis_a_tlast(s_last),
      .m_axis_result_tvalid(mv1), .m_axis_result_tready(m_tready), .m_axis_result_tdata(md1),
      .m_axis_result_tid(mid1), .m_axis_result_tlast(ml1), .m_axis_result_tuser(mu1));

   accumulator_mc #(.OUT_W(16), .SATURATE(0)) dut2 (
      .aclk(aclk), .aresetn(aresetn), .s_clear(s_clear),
      .s_axis_a_tvalid(s_valid), .s_axis_a_tready(rdy2), .s_axis_a_tdata(s_data),
      .s_axis_a_tid(s_id), .s_axis_a_tlast(s_last),
      .m_axis_result_tvalid(mv2), .m_axis_result_tready(m_tready), .m_axis_result_tdata(md2),
      .m_axis_result_tid(mid2), .m_axis_result_tlast(ml2), .m_axis_result_tuser(mu2));

   task automatic cmp(input string name, input logic signed [63:0] act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic logResult(input int k);
      res_t r;
      r = '{e_data[k], e_id, e_cnt[k], e_ovf[k]};
      case (k)
         0:       rq0.push_back(r);
         1:       rq1.push_back(r);
         default: rq2.push_back(r);
      endcase
   endtask

   // Model: exact integer sums, clamped or wrapped against the accumulator and output ranges.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
               m_acc[k][c] = 0;
               m_cnt[k][c] = 0;
               m_ovf[k][c] = 1'b0;
            end
            e_data[k] = 0;
            e_cnt[k]  = 0;
            e_ovf[k]  = 1'b0;
         end
         e_valid    = 1'b0;
         e_ready_en = 1'b0;
         e_id       = 0;
      end else begin
         beat = s_valid && e_ready_en && (!e_valid || m_tready);
         if (e_valid && m_tready) begin
            for (int k = 0; k < 3; k++) logResult(k);
            e_valid = 1'b0;
         end
         for (int k = 0; k < 3; k++) begin
            if (s_clear) begin
               for (int c = 0; c < 4; c++) begin
                  m_acc[k][c] = 0;
                  m_cnt[k][c] = 0;
                  m_ovf[k][c] = 1'b0;
               end
            end
            if (beat) begin
               ms = m_acc[k][s_id] + 64'($signed(s_data));
               mo = m_ovf[k][s_id];
               if (ms > ACC_MAX) begin
                  mo = 1'b1;
                  ms = sat[k] ? ACC_MAX : ms - ACC_SPAN;
               end else if (ms < ACC_MIN) begin
                  mo = 1'b1;
                  ms = sat[k] ? ACC_MIN : ms + ACC_SPAN;
               end
               mc = (m_cnt[k][s_id] == 65535) ? 65535 : m_cnt[k][s_id] + 1;
               if (s_last) begin
                  lim = 64'sd1 <<< (out_w[k] - 1);
                  mr  = ms;
                  if (ms >= lim || ms < -lim) begin
                     mo = 1'b1;
                     if (sat[k]) mr = (ms > 0) ? lim - 1 : -lim;
                     else begin
                        mr = ms & (2 * lim - 1);
                        if (mr >= lim) mr = mr - 2 * lim;
                     end
                  end
                  e_data[k] = mr;
                  e_cnt[k]  = mc;
                  e_ovf[k]  = mo;
                  m_acc[k][s_id] = 0;
                  m_cnt[k][s_id] = 0;
                  m_ovf[k][s_id] = 1'b0;
               end else begin
                  m_acc[k][s_id] = ms;
                  m_cnt[k][s_id] = mc;
                  m_ovf[k][s_id] = mo;
               end
            end
         end
         if (beat && s_last) begin
            e_valid = 1'b1;
            e_id    = int'(s_id);
         end
         e_ready_en = 1'b1;
      end
   end

   task automatic checkInst(input int k, input logic rdy, input logic mv, input logic ml,
                            input logic [1:0] mid, input logic signed [63:0] md, input logic [16:0] mu);
      string p;
      p = $sformatf("inst%0d.", k);
      cmp({p, "s_tready"}, 64'(rdy), 64'(e_ready_en && (!e_valid || m_tready)));
      cmp({p, "m_tvalid"}, 64'(mv), 64'(e_valid));
      cmp({p, "m_tlast"}, 64'(ml), 64'(e_valid));
      if (!aresetn || e_valid) begin
         cmp({p, "m_tdata"}, md, e_data[k]);
         cmp({p, "m_tid"}, 64'(mid), 64'(e_id));
         cmp({p, "m_tuser"}, 64'(mu), (64'(e_ovf[k]) << 16) | 64'(e_cnt[k]));
      end
   endtask

   task automatic checkOutput();
      checkInst(0, rdy0, mv0, ml0, mid0, 64'($signed(md0)), mu0);
      checkInst(1, rdy1, mv1, ml1, mid1, 64'($signed(md1)), mu1);
      checkInst(2, rdy2, mv2, ml2, mid2, 64'($signed(md2)), mu2);
   endtask

   always @(negedge aclk) checkOutput();

   // Drive one beat (called just after a rising edge) and hold it until it is accepted.
   task automatic applyStimulus(input longint data, input int id, input bit last, input bit clr);
      int  budget;
      bit  done;
      logic [63:0] d;
      d       = data;
      s_data  = d[31:0];
      s_id    = id[1:0];
      s_last  = last;
      s_clear = clr;
      s_valid = 1'b1;
      budget  = 50;
      done    = 1'b0;
      while (!done && budget > 0) begin
         @(negedge aclk);
         if (rdy0) done = 1'b1;
         @(posedge aclk);
         #1;
         budget--;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL beat_accept: got no handshake in 50 cycles, expected tready");
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic checkResult(input int k, input longint data, input int id, input int cnt, input bit ovf);
      res_t r;
      bit   have;
      string p;
      have = 1'b0;
      p = $sformatf("inst%0d.result", k);
      case (k)
         0:       if (rq0.size() > 0) begin r = rq0.pop_front(); have = 1'b1; end
         1:       if (rq1.size() > 0) begin r = rq1.pop_front(); have = 1'b1; end
         default: if (rq2.size() > 0) begin r = rq2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL %s: got no result, expected data %0d", p, data);
      end else begin
         cmp({p, ".data"}, r.data, data);
         cmp({p, ".id"}, 64'(r.id), 64'(id));
         cmp({p, ".cnt"}, 64'(r.cnt), 64'(cnt));
         cmp({p, ".ovf"}, 64'(r.ovf), 64'(ovf));
      end
   endtask

   task automatic checkAll(input longint data, input int id, input int cnt);
      for (int k = 0; k < 3; k++) checkResult(k, data, id, cnt, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      s_clear  = 1'b0;
      s_valid  = 1'b0;
      s_last   = 1'b0;
      s_data   = '0;
      s_id     = '0;
      m_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      idle(1);

      $display("[TB] single channel 1..10");
      for (int i = 1; i <= 10; i++) applyStimulus(i, 0, i == 10, 1'b0);
      idle(3);
      checkAll(55, 0, 10);

      $display("[TB] interleaved channels 0 and 1");
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(i, 0, i == 10, 1'b0);
         applyStimulus(i + 10, 1, i == 10, 1'b0);
      end
      idle(3);
      checkAll(55, 0, 10);
      checkAll(155, 1, 10);

      $display("[TB] output backpressure");
      m_tready = 1'b0;
      applyStimulus(100, 2, 1'b0, 1'b0);
      applyStimulus(200, 2, 1'b1, 1'b0);
      fork
         begin
            repeat (5) @(posedge aclk);
            #1 m_tready = 1'b1;
         end
      join_none
      applyStimulus(7, 2, 1'b0, 1'b0);
      applyStimulus(8, 2, 1'b1, 1'b0);
      idle(3);
      checkAll(300, 2, 2);
      checkAll(15, 2, 2);

      $display("[TB] output range saturate and wrap");
      applyStimulus(30000, 1, 1'b0, 1'b0);
      applyStimulus(30000, 1, 1'b1, 1'b0);
      applyStimulus(-30000, 3, 1'b0, 1'b0);
      applyStimulus(-30000, 3, 1'b1, 1'b0);
      idle(3);
      checkResult(0, 60000, 1, 2, 1'b0);
      checkResult(1, 32767, 1, 2, 1'b1);
      checkResult(2, -5536, 1, 2, 1'b1);
      checkResult(0, -60000, 3, 2, 1'b0);
      checkResult(1, -32768, 3, 2, 1'b1);
      checkResult(2, 5536, 3, 2, 1'b1);

      $display("[TB] synchronous clear");
      applyStimulus(100, 0, 1'b0, 1'b0);
      applyStimulus(7, 2, 1'b0, 1'b0);
      applyStimulus(5, 2, 1'b0, 1'b1);
      applyStimulus(1, 2, 1'b1, 1'b0);
      applyStimulus(20, 0, 1'b1, 1'b0);
      idle(3);
      checkAll(6, 2, 2);
      checkAll(20, 0, 1);

      $display("[TB] reset mid-packet");
      applyStimulus(4, 3, 1'b0, 1'b0);
      applyStimulus(4, 3, 1'b0, 1'b0);
      aresetn = 1'b0;
      idle(2);
      aresetn = 1'b1;
      idle(1);
      applyStimulus(2, 3, 1'b0, 1'b0);
      applyStimulus(3, 3, 1'b1, 1'b0);
      idle(3);
      checkAll(5, 3, 2);

      $display("[TB] single-beat packet");
      applyStimulus(-9, 0, 1'b1, 1'b0);
      idle(3);
      checkAll(-9, 0, 1);

      cmp("leftover_results", 64'(rq0.size() + rq1.size() + rq2.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
